mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage of the pipelined MIPS core.
- Holds the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU over a fixed number of cycles, plus MTHI/MTLO writes.
- Its hi/lo outputs feed the EX-stage result-select multiplexer for MFHI/MFLO.
- Its busy output feeds the hazard unit, which stalls dependent MD instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); legal range 1..31
DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..31

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  issue strobe; op is valid this cycle
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
a  input  32  rs operand (already forwarded)
b  input  32  rt operand (already forwarded)
cancel  input  1  exception/interrupt flush; suppresses the issue in this cycle
busy  output  1  operation in progress
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (sync, on rising clk with reset=1): hi=0, lo=0, busy=0, cycle counter=0, pending result discarded. Reset overrides all other inputs, including an in-flight operation.
- Accepted issue: start=1 && cancel=0 && busy=0 at a rising edge. If any of these conditions fails, start has no effect; there is no queue and no error.
- MTHI/MTLO:
  - hi<=a (or lo<=a) at the accepting edge.
  - Visible on the next cycle; busy stays 0.
- MULT/MULTU/DIV/DIVU:
  - At the accepting edge, the result is computed and latched internally, busy<=1, and the counter is loaded with N (MULT_CYCLES or DIV_CYCLES).
  - The counter decrements once per cycle. On the edge where the counter goes 1->0, busy<=0 and hi/lo are loaded from the internal result.
  - If start is accepted at edge t, busy is high for exactly N cycles after t, and new hi/lo appear together with busy=0 after edge t+N.
  - hi/lo hold their old values throughout the busy window.
- Arithmetic:
  - MULT: signed 32x32 -> 64; {hi,lo} = product.
  - MULTU: same as MULT, unsigned.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide overflow: 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
- Divide by zero (b==0): the operation is still timed (busy for DIV_CYCLES), but hi and lo are left unchanged.
- cancel:
  - Affects only the issue in the same cycle.
  - It never aborts an operation already in flight; that instruction has already committed past EX.
- Hazard contract: the hazard unit stalls D-stage MD instructions while (busy | start&op<=3 | start&op>=6). The block itself ignores any start while busy.
- Ops 6/7 when MDU_MADD_EN is undefined: treated as no-op; busy stays 0 and hi/lo are unchanged.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 6/7 (MADD/MADDU) compute {hi,lo} + a*b.
  - Operands are signed for MADD, unsigned for MADDU.
  - Sum is taken mod 2^64, using the {hi,lo} value captured at the accepting edge.
  - Timing is MULT_CYCLES; writeback is the same as MULT.
- Undefined: ops 6/7 are no-ops as stated above, and no accumulate adder is synthesised.

Test Plan:
- Reset then idle -> hi=0, lo=0, busy=0. MTHI a=0x12345678 -> hi=0x12345678 next cycle, busy never asserted.
- MULT a=0xFFFFFFFE, b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU with b=0, hi=0xAAAA0000, lo=0x5555 preloaded -> busy 10 cycles, hi/lo unchanged. A second start issued during busy (MTLO a=1) -> ignored, lo still 0x5555.
- start MULT with cancel=1 -> busy stays 0, hi/lo unchanged. MULT accepted, then cancel=1 on cycle 2 -> operation completes normally. MULT accepted, then reset on cycle 3 -> busy=0, hi=lo=0 next cycle, no later writeback.
- With MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then MADDU a=1, b=1 -> after 5 cycles hi=1, lo=0. Without the macro, the same stimulus -> busy=0 and hi/lo unchanged.

Source files
------------

// File: rtl/mdu_unit.sv
// MIPS EX-stage multiply/divide unit holding HI/LO; MULT/DIV results land after a fixed busy window.
// Optional MADD/MADDU accumulate ops are built when MDU_MADD_EN is defined.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;
`endif
    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [63:0] res_q;
    logic        wb_q;

    logic [63:0] res_d;
    logic [4:0]  cyc_d;
    logic        wb_d;
    logic        long_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, div_s, div_u;
    logic [31:0] q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes; a zero divisor is replaced by 1 so no X
    // is produced, the result is discarded anyway.
    assign a_mag = a[31] ? -a : a;
    assign b_mag = b[31] ? -b : b;
    assign div_s = (b == 32'd0) ? 32'd1 : b_mag;
    assign div_u = (b == 32'd0) ? 32'd1 : b;
    assign q_mag = a_mag / div_s;
    assign r_mag = a_mag % div_s;
    assign quo_s = (a[31] ^ b[31]) ? -q_mag : q_mag;
    assign rem_s = a[31] ? -r_mag : r_mag;
    assign quo_u = a / div_u;
    assign rem_u = a % div_u;

    always_comb begin
        res_d  = {hi_q, lo_q};
        cyc_d  = MULT_N;
        wb_d   = 1'b0;
        long_d = 1'b0;
        case (op)
            OP_MULT:  begin res_d = prod_s;         wb_d = 1'b1; long_d = 1'b1; end
            OP_MULTU: begin res_d = prod_u;         wb_d = 1'b1; long_d = 1'b1; end
            OP_DIV:   begin res_d = {rem_s, quo_s}; wb_d = (b != 32'd0); long_d = 1'b1; cyc_d = DIV_N; end
            OP_DIVU:  begin res_d = {rem_u, quo_u}; wb_d = (b != 32'd0); long_d = 1'b1; cyc_d = DIV_N; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin res_d = {hi_q, lo_q} + prod_s; wb_d = 1'b1; long_d = 1'b1; end
            OP_MADDU: begin res_d = {hi_q, lo_q} + prod_u; wb_d = 1'b1; long_d = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            res_q   <= 64'd0;
            wb_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !cancel) begin
                        if (op == OP_MTHI) hi_q <= a;
                        if (op == OP_MTLO) lo_q <= a;
                        if (long_d) begin
                            state_q <= S_BUSY;
                            cnt_q   <= cyc_d;
                            res_q   <= res_d;
                            wb_q    <= wb_d;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= S_IDLE;
                        if (wb_q) begin
                            hi_q <= res_q[63:32];
                            lo_q <= res_q[31:0];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q == S_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus queues expected HI/LO, a negedge monitor compares.
module tb_mdu_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;
    logic        chk_req = 1'b0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } cmp_t;

    cmp_t done_q[$];
    cmp_t idle_q[$];

    int checks = 0;
    int errors = 0;
    int bcnt = 0;
    bit was_busy = 1'b0;

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a busy 1->0 transition is a completion; chk_req marks an idle-state probe.
    always @(negedge clk) begin
        cmp_t e;
        if (reset) begin
            was_busy = 1'b0;
            bcnt = 0;
        end else begin
            if (busy === 1'b1) bcnt++;
            if (was_busy && busy === 1'b0) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_completion: hi=0x%08h lo=0x%08h", hi, lo);
                end else begin
                    e = done_q.pop_front();
                    cmp("done_hi", hi, e.hi);
                    cmp("done_lo", lo, e.lo);
                    cmp("busy_cycles", 32'(bcnt), 32'(e.cyc));
                end
                bcnt = 0;
            end
            was_busy = (busy === 1'b1);
        end
        if (chk_req) begin
            if (idle_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL idle_probe: no expectation queued");
            end else begin
                e = idle_q.pop_front();
                cmp("idle_busy", {31'd0, busy}, 32'd0);
                cmp("idle_hi", hi, e.hi);
                cmp("idle_lo", lo, e.lo);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic c);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y; cancel = c;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
    endtask

    task automatic expect_done(input logic [31:0] h, input logic [31:0] l, input int n);
        cmp_t e;
        e.hi = h; e.lo = l; e.cyc = n;
        done_q.push_back(e);
    endtask

    task automatic idle_check(input logic [31:0] h, input logic [31:0] l);
        cmp_t e;
        e.hi = h; e.lo = l; e.cyc = 0;
        idle_q.push_back(e);
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle: busy still 0x%0h after 100 cycles, expected 0", busy);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle_check(32'h0, 32'h0);

        issue(3'd4, 32'h12345678, 32'h0, 1'b0);
        idle_check(32'h12345678, 32'h0);

        expect_done(32'hFFFFFFFF, 32'hFFFFFFFA, MC);
        issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        wait_idle();
        expect_done(32'h00000002, 32'hFFFFFFFA, MC);
        issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        wait_idle();

        expect_done(32'hFFFFFFFF, 32'hFFFFFFFD, DC);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_idle();
        expect_done(32'h1, 32'h3, DC);
        issue(3'd3, 32'd7, 32'd2, 1'b0);
        wait_idle();
        expect_done(32'h0, 32'h80000000, DC);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle();

        issue(3'd4, 32'hAAAA0000, 32'h0, 1'b0);
        issue(3'd5, 32'h00005555, 32'h0, 1'b0);
        idle_check(32'hAAAA0000, 32'h00005555);
        expect_done(32'hAAAA0000, 32'h00005555, DC);
        issue(3'd3, 32'd100, 32'd0, 1'b0);
        issue(3'd5, 32'd1, 32'd0, 1'b0);
        wait_idle();
        idle_check(32'hAAAA0000, 32'h00005555);

        issue(3'd0, 32'd5, 32'd6, 1'b1);
        idle_check(32'hAAAA0000, 32'h00005555);

        expect_done(32'h0, 32'hC, MC);
        issue(3'd0, 32'd3, 32'd4, 1'b0);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        wait_idle();

        issue(3'd0, 32'h7, 32'h9, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_check(32'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        idle_check(32'h0, 32'h0);

        issue(3'd4, 32'h0, 32'h0, 1'b0);
        issue(3'd5, 32'hFFFFFFFF, 32'h0, 1'b0);
`ifdef MDU_MADD_EN
        expect_done(32'h1, 32'h0, MC);
        issue(3'd7, 32'd1, 32'd1, 1'b0);
        wait_idle();
`else
        issue(3'd7, 32'd1, 32'd1, 1'b0);
        idle_check(32'h0, 32'hFFFFFFFF);
        repeat (MC + 2) @(posedge clk);
        #1;
        idle_check(32'h0, 32'hFFFFFFFF);
`endif

        repeat (3) @(posedge clk);
        checks++;
        if (done_q.size() != 0 || idle_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: %0d completions and %0d probes left, expected 0",
                     done_q.size(), idle_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
